// File: rtl/ram_wr_arbiter_if.sv
// Request and RAM write-port bundle of the dual-lane RAM write arbiter.
// The arbiter connects through the master modport, its environment through slave.
interface ram_wr_arbiter_if #(
  parameter int ADDR_WIDTH       = 11,
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int DATA_TYPE_WIDTH  = 2
);
  logic                        req0_valid;
  logic                        req0_ready;
  logic [ADDR_WIDTH-1:0]       req0_addr;
  logic [DOUBLEWORD_WIDTH-1:0] req0_data;
  logic [DATA_TYPE_WIDTH-1:0]  req0_type;

  logic                        req1_valid;
  logic                        req1_ready;
  logic [ADDR_WIDTH-1:0]       req1_addr;
  logic [DOUBLEWORD_WIDTH-1:0] req1_data;
  logic [DATA_TYPE_WIDTH-1:0]  req1_type;

  logic                        mem_wr_ins;
  logic [ADDR_WIDTH-1:0]       mem_addr_wr;
  logic [DOUBLEWORD_WIDTH-1:0] mem_data_bus_wr;
  logic [DATA_TYPE_WIDTH-1:0]  mem_data_type_wr;
  logic                        mem_wr_idle;

  logic                        grant_lane;
  logic                        err_valid;
  logic                        err_lane;
  logic                        busy;

  modport master (
    input  req0_valid, req0_addr, req0_data, req0_type,
    input  req1_valid, req1_addr, req1_data, req1_type,
    input  mem_wr_idle,
    output req0_ready, req1_ready,
    output mem_wr_ins, mem_addr_wr, mem_data_bus_wr, mem_data_type_wr,
    output grant_lane, err_valid, err_lane, busy
  );

  modport slave (
    output req0_valid, req0_addr, req0_data, req0_type,
    output req1_valid, req1_addr, req1_data, req1_type,
    output mem_wr_idle,
    input  req0_ready, req1_ready,
    input  mem_wr_ins, mem_addr_wr, mem_data_bus_wr, mem_data_type_wr,
    input  grant_lane, err_valid, err_lane, busy
  );
endinterface

// File: rtl/ram_wr_arbiter.sv
// Round-robin arbiter sharing the data-RAM write port between two issue lanes,
// with a small per-lane FIFO and a drop-and-report path for illegal requests.
module ram_wr_arbiter #(
  parameter int ADDR_DEPTH       = 2048,
  parameter int ADDR_WIDTH       = $clog2(ADDR_DEPTH),
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int DATA_TYPE_WIDTH  = 2,
  parameter int FIFO_DEPTH       = 2
) (
  input  logic              clk,
  input  logic              rst,
  ram_wr_arbiter_if.master  bus
);

  localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]       addr;
    logic [DOUBLEWORD_WIDTH-1:0] data;
    logic [DATA_TYPE_WIDTH-1:0]  dtype;
  } entry_t;

  function automatic logic is_legal(input entry_t e);
    logic ok;
    if (e.dtype == DATA_TYPE_WIDTH'(0))
      ok = 1'b1;
    else if (e.dtype == DATA_TYPE_WIDTH'(1))
      ok = (e.addr[1:0] == 2'b00);
    else if (e.dtype == DATA_TYPE_WIDTH'(2))
      ok = (e.addr[2:0] == 3'b000);
    else
      ok = 1'b0;
    return ok;
  endfunction

  entry_t               fifo_mem [2][FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr   [2];
  logic [PTR_WIDTH-1:0] rd_ptr   [2];
  logic [PTR_WIDTH:0]   count    [2];
  entry_t               in_entry [2];
  logic [1:0]           in_valid;
  logic [1:0]           push;
  logic [1:0]           pop;
  logic [1:0]           full;
  logic [1:0]           empty;

  state_t                      state;
  logic                        last_grant;
  logic                        win;
  logic                        grant_ok;
  logic                        head_legal;
  entry_t                      head;

  logic                        wr_ins_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DOUBLEWORD_WIDTH-1:0] data_q;
  logic [DATA_TYPE_WIDTH-1:0]  type_q;
  logic                        grant_lane_q;
  logic                        err_valid_q;
  logic                        err_lane_q;

  always_comb begin
    in_valid    = {bus.req1_valid, bus.req0_valid};
    in_entry[0] = {bus.req0_addr, bus.req0_data, bus.req0_type};
    in_entry[1] = {bus.req1_addr, bus.req1_data, bus.req1_type};
    full  = '0;
    empty = '0;
    push  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      full[i]  = (count[i] == FULL_COUNT);
      empty[i] = (count[i] == '0);
      push[i]  = in_valid[i] && !full[i];
    end
  end

  assign bus.req0_ready = !full[0];
  assign bus.req1_ready = !full[1];

  // FIFO payload needs no reset: reset empties the FIFOs through the pointers.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i])
        fifo_mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + (PTR_WIDTH + 1)'(push[i]) - (PTR_WIDTH + 1)'(pop[i]);
      end
    end
  end

  always_comb begin
    win        = (!empty[0] && !empty[1]) ? !last_grant : empty[0];
    head       = fifo_mem[win][rd_ptr[win]];
    head_legal = is_legal(head);
    grant_ok   = bus.mem_wr_idle && (empty != 2'b11) &&
                 ((state == ARB) || (state == WAIT));
    pop        = '0;
    pop[win]   = grant_ok;
  end

  // WAIT arbitrates directly once the RAM is idle again, folding the return
  // to ARB into the grant so back-to-back writes keep a 3-cycle cadence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB;
      last_grant   <= 1'b1;
      wr_ins_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      type_q       <= '0;
      grant_lane_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_lane_q   <= 1'b0;
    end else begin
      wr_ins_q    <= 1'b0;
      err_valid_q <= 1'b0;
      case (state)
        ARB, WAIT: begin
          if (grant_ok) begin
            last_grant <= win;
            if (head_legal) begin
              addr_q       <= head.addr;
              data_q       <= head.data;
              type_q       <= head.dtype;
              grant_lane_q <= win;
              wr_ins_q     <= 1'b1;
              state        <= ISSUE;
            end else begin
              err_valid_q <= 1'b1;
              err_lane_q  <= win;
              state       <= ARB;
            end
          end else if (bus.mem_wr_idle) begin
            state <= ARB;
          end
        end
        ISSUE:   state <= WAIT;
        default: state <= ARB;
      endcase
    end
  end

  assign bus.mem_wr_ins       = wr_ins_q;
  assign bus.mem_addr_wr      = addr_q;
  assign bus.mem_data_bus_wr  = data_q;
  assign bus.mem_data_type_wr = type_q;
  assign bus.grant_lane       = grant_lane_q;
  assign bus.err_valid        = err_valid_q;
  assign bus.err_lane         = err_lane_q;
  assign bus.busy             = (state != ARB) || (empty != 2'b11);

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Directed bench for ram_wr_arbiter with a two-cycle-write RAM model.
module tb_ram_wr_arbiter;

  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_wr_arbiter_if #(.ADDR_WIDTH(AW), .DOUBLEWORD_WIDTH(64), .DATA_TYPE_WIDTH(2)) bus ();

  ram_wr_arbiter #(
    .ADDR_DEPTH(2048),
    .DOUBLEWORD_WIDTH(64),
    .DATA_TYPE_WIDTH(2),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model: wr_ins latches the write, next cycle is the load cycle (idle low).
  logic [7:0]    ram [2048];
  logic          load = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] l_addr;
  logic [63:0]   l_data;
  logic [1:0]    l_type;

  assign bus.mem_wr_idle = !load && !hold;

  always @(posedge clk) begin
    if (load) begin
      for (int b = 0; b < 8; b++) begin
        if ((b < ((l_type == 2'd0) ? 1 : (l_type == 2'd1) ? 4 : 8)) && (int'(l_addr) + b < 2048))
          ram[int'(l_addr) + b] <= l_data[8*b +: 8];
      end
      load <= 1'b0;
    end else if (bus.mem_wr_ins) begin
      l_addr <= bus.mem_addr_wr;
      l_data <= bus.mem_data_bus_wr;
      l_type <= bus.mem_data_type_wr;
      load   <= 1'b1;
    end
  end

  function automatic logic [63:0] rd64(input int a);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = ram[a + b];
    return r;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            s_cyc  [$];
  logic          s_lane [$];
  logic [AW-1:0] s_addr [$];
  logic          e_lane [$];

  always @(negedge clk) begin
    if (bus.mem_wr_ins) begin
      s_cyc.push_back(cyc);
      s_lane.push_back(bus.grant_lane);
      s_addr.push_back(bus.mem_addr_wr);
    end
    if (bus.err_valid) e_lane.push_back(bus.err_lane);
  end

  task automatic clear_mon();
    s_cyc.delete();
    s_lane.delete();
    s_addr.delete();
    e_lane.delete();
  endtask

  // Called at a negedge; returns at a negedge after the request is accepted.
  task automatic push(input logic lane, input logic [AW-1:0] a, input logic [63:0] d,
                      input logic [1:0] t);
    logic done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (lane == 1'b0) begin
        bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d; bus.req0_type = t;
        done = bus.req0_ready;
      end else begin
        bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d; bus.req1_type = t;
        done = bus.req1_ready;
      end
      @(negedge clk);
    end
    if (lane == 1'b0) bus.req0_valid = 1'b0;
    else              bus.req1_valid = 1'b0;
    if (!done) check("push_accept", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((bus.busy || load || hold) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(n < 100), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pc;
    int i0;
    int i1;
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0; bus.req0_type = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0; bus.req1_type = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_wr_ins",    64'(bus.mem_wr_ins), 64'd0);
    check("rst_addr",      64'(bus.mem_addr_wr), 64'd0);
    check("rst_data",      bus.mem_data_bus_wr, 64'd0);
    check("rst_type",      64'(bus.mem_data_type_wr), 64'd0);
    check("rst_grant",     64'(bus.grant_lane), 64'd0);
    check("rst_err_valid", 64'(bus.err_valid), 64'd0);
    check("rst_err_lane",  64'(bus.err_lane), 64'd0);
    check("rst_busy",      64'(bus.busy), 64'd0);
    check("rst_ready0",    64'(bus.req0_ready), 64'd1);
    check("rst_ready1",    64'(bus.req1_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single doubleword write
    clear_mon();
    pc = cyc;
    push(1'b0, 11'h010, 64'h1122334455667788, 2'd2);
    wait_done("single");
    check("single_count",   64'(s_cyc.size()), 64'd1);
    check("single_latency", 64'((s_cyc.size() > 0) ? s_cyc[0] - pc : -1), 64'd2);
    check("single_lane",    64'((s_lane.size() > 0) ? s_lane[0] : 1'bx), 64'd0);
    check("single_addr",    64'((s_addr.size() > 0) ? s_addr[0] : 'x), 64'h010);
    check("single_ram",     rd64(11'h010), 64'h1122334455667788);
    check("single_byte0",   64'(ram[16'h010]), 64'h88);
    check("single_hold",    bus.mem_data_bus_wr, 64'h1122334455667788);

    // Contention: both lanes push every cycle until their two entries are in
    apply_reset();
    clear_mon();
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        check("cont_ready1_full", 64'(bus.req1_ready), 64'd0);
        check("cont_ready0",      64'(bus.req0_ready), 64'd1);
      end
      bus.req0_valid = (i0 < 2) && bus.req0_ready;
      bus.req0_addr  = 11'(32'h100 + 8 * i0);
      bus.req0_data  = 64'h0A00 + 64'(i0);
      bus.req0_type  = 2'd2;
      bus.req1_valid = (i1 < 2) && bus.req1_ready;
      bus.req1_addr  = 11'(32'h200 + 8 * i1);
      bus.req1_data  = 64'h0B00 + 64'(i1);
      bus.req1_type  = 2'd2;
      if (bus.req0_valid) i0++;
      if (bus.req1_valid) i1++;
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_done("cont");
    check("cont_count", 64'(s_cyc.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_lane%0d", i), 64'((s_lane.size() > i) ? s_lane[i] : 1'bx), 64'(i % 2));
      check($sformatf("cont_addr%0d", i), 64'((s_addr.size() > i) ? s_addr[i] : 'x),
            64'(((i % 2) == 0 ? 32'h100 : 32'h200) + 8 * (i / 2)));
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("cont_gap%0d", i),
            64'((s_cyc.size() > i + 1) ? s_cyc[i+1] - s_cyc[i] : -1), 64'd3);
    check("cont_ram", rd64(11'h208), 64'h0B01);

    // Misaligned word from lane 1, legal doubleword from lane 0 behind it
    apply_reset();
    clear_mon();
    push(1'b1, 11'h006, 64'hDEAD_BEEF, 2'd1);
    push(1'b0, 11'h030, 64'h0123456789ABCDEF, 2'd2);
    wait_done("misal");
    check("misal_err_count", 64'(e_lane.size()), 64'd1);
    check("misal_err_lane",  64'((e_lane.size() > 0) ? e_lane[0] : 1'bx), 64'd1);
    check("misal_wr_count",  64'(s_cyc.size()), 64'd1);
    check("misal_wr_lane",   64'((s_lane.size() > 0) ? s_lane[0] : 1'bx), 64'd0);
    check("misal_ram",       rd64(11'h030), 64'h0123456789ABCDEF);
    check("misal_untouched", 64'(ram[6]), 64'h00);

    // Illegal type from lane 0
    clear_mon();
    push(1'b0, 11'h000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    wait_done("illeg");
    check("illeg_err_count", 64'(e_lane.size()), 64'd1);
    check("illeg_err_lane",  64'((e_lane.size() > 0) ? e_lane[0] : 1'bx), 64'd0);
    check("illeg_wr_count",  64'(s_cyc.size()), 64'd0);
    check("illeg_ram",       rd64(0), 64'd0);
    check("illeg_addr_hold", 64'(bus.mem_addr_wr), 64'h030);

    // Four byte writes through a two-entry FIFO
    clear_mon();
    for (int i = 0; i < 4; i++) push(1'b0, 11'(32'h020 + i), 64'(32'hA0 + i), 2'd0);
    wait_done("byte");
    check("byte_count", 64'(s_cyc.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("byte_addr%0d", i), 64'((s_addr.size() > i) ? s_addr[i] : 'x), 64'(32'h020 + i));
      check($sformatf("byte_ram%0d", i), 64'(ram[32'h020 + i]), 64'(32'hA0 + i));
    end
    check("byte_neighbour", 64'(ram[32'h024]), 64'h00);

    // RAM busy elsewhere: no grant until wr_idle returns
    clear_mon();
    hold = 1'b1;
    push(1'b1, 11'h040, 64'h55, 2'd0);
    repeat (5) @(negedge clk);
    check("hold_no_wr", 64'(s_cyc.size()), 64'd0);
    check("hold_busy",  64'(bus.busy), 64'd1);
    hold = 1'b0;
    wait_done("hold");
    check("hold_wr_count", 64'(s_cyc.size()), 64'd1);
    check("hold_wr_addr",  64'((s_addr.size() > 0) ? s_addr[0] : 'x), 64'h040);

    // Reset during ISSUE with two lane-1 entries queued
    apply_reset();
    clear_mon();
    hold = 1'b1;
    push(1'b0, 11'h050, 64'h5050, 2'd2);
    push(1'b1, 11'h058, 64'h5858, 2'd2);
    push(1'b1, 11'h060, 64'h6060, 2'd2);
    check("mid_ready1_full", 64'(bus.req1_ready), 64'd0);
    hold = 1'b0;
    @(posedge clk);
    #1;
    check("mid_issue",      64'(bus.mem_wr_ins), 64'd1);
    check("mid_issue_lane", 64'(bus.grant_lane), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_wr_ins_drop", 64'(bus.mem_wr_ins), 64'd0);
    check("mid_ready1",      64'(bus.req1_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    @(negedge clk);
    check("mid_busy", 64'(bus.busy), 64'd0);
    repeat (6) @(negedge clk);
    check("mid_no_wr", 64'(s_cyc.size()), 64'd0);
    check("mid_ram58", rd64(11'h058), 64'd0);
    check("mid_ram60", rd64(11'h060), 64'd0);
    push(1'b1, 11'h068, 64'hCAFE_F00D_1234_5678, 2'd2);
    wait_done("post");
    check("post_count", 64'(s_cyc.size()), 64'd1);
    check("post_lane",  64'((s_lane.size() > 0) ? s_lane[0] : 1'bx), 64'd1);
    check("post_ram",   rd64(11'h068), 64'hCAFE_F00D_1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
